pcie_hcmd_slot_req: RTL and testbench

Requester side of the host-command slot allocator. Accepts new host commands on a ready/valid port, obtains a slot tag through the allocator's `hcmd_slot_rdy` / `hcmd_slot_alloc_en` handshake, and returns the command ID paired with its tag. On the return path it queues command-completion tags and drives `hcmd_slot_free_en` / `hcmd_slot_invalid_tag` back to the allocator, one tag per cycle. It also keeps a live count of outstanding slots.

---
 rtl/pcie_hcmd_slot_pkg.sv | 10 +
 rtl/pcie_hcmd_slot_free_fifo.sv | 38 +++
 rtl/pcie_hcmd_slot_req.sv | 104 ++++++++++
 tb/tb_pcie_hcmd_slot_req.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pcie_hcmd_slot_pkg.sv
// pcie_hcmd_slot_pkg: shared widths, one-hot FSM states and slot count type for the slot requester
package pcie_hcmd_slot_pkg;
  localparam int C_SLOT_WIDTH = 1024;
  localparam int C_SLOT_TAG_WIDTH = 10;
  typedef logic [C_SLOT_TAG_WIDTH:0] slot_cnt_t;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'b001;
  localparam state_t S_WAIT_SLOT = 3'b010;
  localparam state_t S_GNT = 3'b100;
endpackage

// File: rtl/pcie_hcmd_slot_free_fifo.sv
// pcie_hcmd_slot_free_fifo: synchronous tag FIFO for completion tags awaiting release
// Ports: clk/rst_n (async active-low), push/din write side, pop/dout read side (dout is the head), full/empty flags.
module pcie_hcmd_slot_free_fifo #(
  parameter int P_DEPTH = 8,
  parameter int P_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [P_WIDTH-1:0] din,
  input  logic               pop,
  output logic [P_WIDTH-1:0] dout,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(P_DEPTH);
  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push};
    rd_d = rd_q + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end
  assign dout = mem_q[rd_q[AW-1:0]];
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/pcie_hcmd_slot_req.sv
// pcie_hcmd_slot_req: host-command slot requester (tag allocation handshake, completion free path, outstanding count)
// Ports: cmd_req_* in / cmd_gnt_* out (id+tag pairing), hcmd_slot_* allocator handshake, cpl_tag_* completions,
// hcmd_slot_free_en/invalid_tag free strobe, slot_outstanding_cnt, dbl_free_err.
// Optional macro PCIE_HCMD_SLOT_DBL_FREE_CHK_EN adds a busy bitmap that drops frees of unallocated tags.
module pcie_hcmd_slot_req
  import pcie_hcmd_slot_pkg::*;
#(
  parameter int P_SLOT_WIDTH = C_SLOT_WIDTH,
  parameter int P_SLOT_TAG_WIDTH = C_SLOT_TAG_WIDTH,
  parameter int P_CMD_ID_WIDTH = 16,
  parameter int P_FREE_FIFO_DEPTH = 8
) (
  input  logic                        pcie_user_clk,
  input  logic                        pcie_user_rst_n,
  input  logic                        cmd_req_valid,
  input  logic [P_CMD_ID_WIDTH-1:0]   cmd_req_id,
  output logic                        cmd_req_ready,
  output logic                        cmd_gnt_valid,
  output logic [P_CMD_ID_WIDTH-1:0]   cmd_gnt_id,
  output logic [P_SLOT_TAG_WIDTH-1:0] cmd_gnt_tag,
  input  logic                        hcmd_slot_rdy,
  input  logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_tag,
  output logic                        hcmd_slot_alloc_en,
  input  logic                        cpl_tag_valid,
  input  logic [P_SLOT_TAG_WIDTH-1:0] cpl_tag,
  output logic                        cpl_tag_ready,
  output logic                        hcmd_slot_free_en,
  output logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_invalid_tag,
  output slot_cnt_t                   slot_outstanding_cnt,
  output logic                        dbl_free_err
);
  state_t state_q, state_d;
  logic [P_CMD_ID_WIDTH-1:0] id_q, id_d;
  logic [P_SLOT_TAG_WIDTH-1:0] tag_q, tag_d, inv_tag_q, inv_tag_d, head_tag;
  logic free_en_q, free_en_d, err_q, err_d;
  logic fifo_full, fifo_empty, push, pop, free_ok;
  slot_cnt_t cnt_q, cnt_d;
  assign push = cpl_tag_valid & ~fifo_full;
  assign pop = ~fifo_empty;
  pcie_hcmd_slot_free_fifo #(.P_DEPTH(P_FREE_FIFO_DEPTH), .P_WIDTH(P_SLOT_TAG_WIDTH)) u_free_fifo (
    .clk(pcie_user_clk), .rst_n(pcie_user_rst_n), .push(push), .din(cpl_tag),
    .pop(pop), .dout(head_tag), .full(fifo_full), .empty(fifo_empty)
  );
`ifdef PCIE_HCMD_SLOT_DBL_FREE_CHK_EN
  logic [P_SLOT_WIDTH-1:0] busy_q, busy_d;
  assign free_ok = busy_q[head_tag];
  // A set on alloc is applied after the clear so a same-cycle alloc of the freed tag leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (pop & free_ok) busy_d[head_tag] = 1'b0;
    if (hcmd_slot_alloc_en) busy_d[hcmd_slot_tag] = 1'b1;
  end
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  end
`else
  assign free_ok = 1'b1;
`endif
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      state_q <= S_IDLE;
      id_q <= '0;
      tag_q <= '0;
      free_en_q <= 1'b0;
      inv_tag_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      tag_q <= tag_d;
      free_en_q <= free_en_d;
      inv_tag_q <= inv_tag_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = (state_q == S_IDLE) ? (cmd_req_valid ? S_WAIT_SLOT : S_IDLE) :
              (state_q == S_WAIT_SLOT) ? (hcmd_slot_rdy ? S_GNT : S_WAIT_SLOT) : S_IDLE;
  end
  always_comb begin
    cmd_req_ready = (state_q == S_IDLE) & pcie_user_rst_n;
    hcmd_slot_alloc_en = (state_q == S_WAIT_SLOT) & hcmd_slot_rdy;
    cmd_gnt_valid = state_q == S_GNT;
  end
  always_comb begin
    id_d = (cmd_req_valid & cmd_req_ready) ? cmd_req_id : id_q;
    tag_d = hcmd_slot_alloc_en ? hcmd_slot_tag : tag_q;
    free_en_d = pop & free_ok;
    inv_tag_d = (pop & free_ok) ? head_tag : inv_tag_q;
    err_d = pop & ~free_ok;
    cnt_d = (hcmd_slot_alloc_en & ~free_en_q & (cnt_q != slot_cnt_t'(P_SLOT_WIDTH))) ? cnt_q + 1'b1 :
            (~hcmd_slot_alloc_en & free_en_q & (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
  end
  assign cpl_tag_ready = ~fifo_full;
  assign cmd_gnt_id = id_q;
  assign cmd_gnt_tag = tag_q;
  assign hcmd_slot_free_en = free_en_q;
  assign hcmd_slot_invalid_tag = inv_tag_q;
  assign slot_outstanding_cnt = cnt_q;
  assign dbl_free_err = err_q;
endmodule

// File: tb/tb_pcie_hcmd_slot_req.sv
// tb_pcie_hcmd_slot_req: directed self-checking bench for pcie_hcmd_slot_req
module tb_pcie_hcmd_slot_req;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_req_valid = 1'b0;
  logic [15:0] cmd_req_id = '0;
  logic cmd_req_ready, cmd_gnt_valid, hcmd_slot_alloc_en, cpl_tag_ready, free_en, dbl_free_err;
  logic [15:0] cmd_gnt_id;
  logic [9:0] cmd_gnt_tag, inv_tag;
  logic hcmd_slot_rdy = 1'b0;
  logic [9:0] hcmd_slot_tag = '0;
  logic cpl_tag_valid = 1'b0;
  logic [9:0] cpl_tag = '0;
  logic [10:0] cnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pcie_hcmd_slot_req dut (
    .pcie_user_clk(clk), .pcie_user_rst_n(rst_n),
    .cmd_req_valid(cmd_req_valid), .cmd_req_id(cmd_req_id), .cmd_req_ready(cmd_req_ready),
    .cmd_gnt_valid(cmd_gnt_valid), .cmd_gnt_id(cmd_gnt_id), .cmd_gnt_tag(cmd_gnt_tag),
    .hcmd_slot_rdy(hcmd_slot_rdy), .hcmd_slot_tag(hcmd_slot_tag), .hcmd_slot_alloc_en(hcmd_slot_alloc_en),
    .cpl_tag_valid(cpl_tag_valid), .cpl_tag(cpl_tag), .cpl_tag_ready(cpl_tag_ready),
    .hcmd_slot_free_en(free_en), .hcmd_slot_invalid_tag(inv_tag),
    .slot_outstanding_cnt(cnt), .dbl_free_err(dbl_free_err)
  );

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (cmd_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", cmd_req_ready); end
    total++; if ({cmd_gnt_valid, hcmd_slot_alloc_en, free_en, dbl_free_err} !== 4'b0) begin bad++; $display("FAIL rst_strobes got=%b exp=0000", {cmd_gnt_valid, hcmd_slot_alloc_en, free_en, dbl_free_err}); end
    total++; if ({cmd_gnt_id, cmd_gnt_tag, inv_tag, cnt} !== '0) begin bad++; $display("FAIL rst_values id=%h tag=%h inv=%h cnt=%0d exp all 0", cmd_gnt_id, cmd_gnt_tag, inv_tag, cnt); end
    rst_n = 1'b1;
    #1;
    total++; if (cmd_req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", cmd_req_ready); end
  endtask

  task automatic do_alloc(input logic [15:0] id, input logic [9:0] tag, input int exp_cnt);
    @(negedge clk);
    total++; if (cmd_req_ready !== 1'b1) begin bad++; $display("FAIL alloc_idle_ready got=%b exp=1", cmd_req_ready); end
    cmd_req_valid = 1'b1; cmd_req_id = id; hcmd_slot_rdy = 1'b1; hcmd_slot_tag = tag;
    @(negedge clk);
    cmd_req_valid = 1'b0;
    #1;
    total++; if ({hcmd_slot_alloc_en, cmd_req_ready, cmd_gnt_valid} !== 3'b100) begin bad++; $display("FAIL alloc_en alloc/ready/gnt got=%b exp=100", {hcmd_slot_alloc_en, cmd_req_ready, cmd_gnt_valid}); end
    @(negedge clk);
    hcmd_slot_rdy = 1'b0;
    total++; if ({cmd_gnt_valid, hcmd_slot_alloc_en, cmd_req_ready} !== 3'b100) begin bad++; $display("FAIL gnt_pulse gnt/alloc/ready got=%b exp=100", {cmd_gnt_valid, hcmd_slot_alloc_en, cmd_req_ready}); end
    total++; if (cmd_gnt_id !== id || cmd_gnt_tag !== tag) begin bad++; $display("FAIL gnt_pair got=%h/%h exp=%h/%h", cmd_gnt_id, cmd_gnt_tag, id, tag); end
    total++; if (cnt !== 11'(exp_cnt)) begin bad++; $display("FAIL alloc_cnt got=%0d exp=%0d", cnt, exp_cnt); end
  endtask

  task automatic test_alloc;
    do_alloc(16'h1234, 10'h3BC, 1);
    @(negedge clk);
    total++; if (cmd_gnt_valid !== 1'b0 || cmd_req_ready !== 1'b1) begin bad++; $display("FAIL gnt_end gnt=%b ready=%b exp 0/1", cmd_gnt_valid, cmd_req_ready); end
  endtask

  task automatic test_wait;
    cmd_req_valid = 1'b1; cmd_req_id = 16'hBEEF; hcmd_slot_rdy = 1'b0;
    @(negedge clk);
    cmd_req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++; if (hcmd_slot_alloc_en !== 1'b0 || cmd_req_ready !== 1'b0) begin bad++; $display("FAIL wait_cycle%0d alloc=%b ready=%b exp 0/0", i, hcmd_slot_alloc_en, cmd_req_ready); end
      @(negedge clk);
    end
    hcmd_slot_rdy = 1'b1; hcmd_slot_tag = 10'h055;
    #1;
    total++; if (hcmd_slot_alloc_en !== 1'b1) begin bad++; $display("FAIL wait_rdy_alloc got=%b exp=1", hcmd_slot_alloc_en); end
    @(negedge clk);
    hcmd_slot_rdy = 1'b0;
    total++; if (cmd_gnt_valid !== 1'b1 || cmd_gnt_id !== 16'hBEEF || cmd_gnt_tag !== 10'h055 || cnt !== 11'd2) begin bad++; $display("FAIL wait_gnt v=%b id=%h tag=%h cnt=%0d exp 1/beef/055/2", cmd_gnt_valid, cmd_gnt_id, cmd_gnt_tag, cnt); end
  endtask

  task automatic test_burst;
    logic [9:0] bt [8];
    for (int i = 0; i < 8; i++) begin
      bt[i] = 10'(10'h100 + 10'(i * 7));
      do_alloc(16'(16'h0A00 + i), bt[i], 3 + i);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 10) begin
        total++; if (free_en !== 1'b1 || inv_tag !== bt[i-2]) begin bad++; $display("FAIL burst_free%0d en=%b tag=%h exp 1/%h", i - 2, free_en, inv_tag, bt[i-2]); end
      end else begin
        total++; if (free_en !== 1'b0) begin bad++; $display("FAIL burst_idle%0d en=%b exp=0", i, free_en); end
      end
      if (i < 8) begin
        total++; if (cpl_tag_ready !== 1'b1) begin bad++; $display("FAIL burst_ready%0d got=%b exp=1", i, cpl_tag_ready); end
        cpl_tag_valid = 1'b1; cpl_tag = bt[i];
      end else cpl_tag_valid = 1'b0;
    end
    total++; if (cnt !== 11'd2) begin bad++; $display("FAIL burst_cnt got=%0d exp=2", cnt); end
  endtask

  task automatic test_same_cycle;
    for (int i = 0; i < 3; i++) do_alloc(16'(16'h0B00 + i), 10'(10'h201 + i), 3 + i);
    @(negedge clk);
    total++; if (cnt !== 11'd5) begin bad++; $display("FAIL same_pre_cnt got=%0d exp=5", cnt); end
    cmd_req_valid = 1'b1; cmd_req_id = 16'h0505; hcmd_slot_rdy = 1'b0;
    cpl_tag_valid = 1'b1; cpl_tag = 10'h3BC;
    @(negedge clk);
    cmd_req_valid = 1'b0; cpl_tag_valid = 1'b0;
    @(negedge clk);
    hcmd_slot_rdy = 1'b1; hcmd_slot_tag = 10'h2AA;
    #1;
    total++; if (hcmd_slot_alloc_en !== 1'b1 || free_en !== 1'b1 || inv_tag !== 10'h3BC) begin bad++; $display("FAIL same_overlap alloc=%b free=%b tag=%h exp 1/1/3bc", hcmd_slot_alloc_en, free_en, inv_tag); end
    @(negedge clk);
    hcmd_slot_rdy = 1'b0;
    total++; if (cmd_gnt_valid !== 1'b1 || cnt !== 11'd5) begin bad++; $display("FAIL same_cnt gnt=%b cnt=%0d exp 1/5", cmd_gnt_valid, cnt); end
    @(negedge clk);
    total++; if (cnt !== 11'd5) begin bad++; $display("FAIL same_cnt_hold got=%0d exp=5", cnt); end
  endtask

  task automatic test_free_unalloc;
    @(negedge clk);
    cpl_tag_valid = 1'b1; cpl_tag = 10'h010;
    @(negedge clk);
    cpl_tag_valid = 1'b0;
    total++; if (free_en !== 1'b0 || dbl_free_err !== 1'b0) begin bad++; $display("FAIL unalloc_early free=%b err=%b exp 0/0", free_en, dbl_free_err); end
    @(negedge clk);
`ifdef PCIE_HCMD_SLOT_DBL_FREE_CHK_EN
    total++; if (free_en !== 1'b0 || dbl_free_err !== 1'b1) begin bad++; $display("FAIL unalloc_drop free=%b err=%b exp 0/1", free_en, dbl_free_err); end
`else
    total++; if (free_en !== 1'b1 || inv_tag !== 10'h010 || dbl_free_err !== 1'b0) begin bad++; $display("FAIL unalloc_free free=%b tag=%h err=%b exp 1/010/0", free_en, inv_tag, dbl_free_err); end
`endif
    @(negedge clk);
`ifdef PCIE_HCMD_SLOT_DBL_FREE_CHK_EN
    total++; if (dbl_free_err !== 1'b0 || free_en !== 1'b0 || cnt !== 11'd5) begin bad++; $display("FAIL unalloc_after err=%b free=%b cnt=%0d exp 0/0/5", dbl_free_err, free_en, cnt); end
`else
    total++; if (dbl_free_err !== 1'b0 || free_en !== 1'b0 || cnt !== 11'd4) begin bad++; $display("FAIL unalloc_after err=%b free=%b cnt=%0d exp 0/0/4", dbl_free_err, free_en, cnt); end
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cmd_req_valid = 1'b1; cmd_req_id = 16'h7777; hcmd_slot_rdy = 1'b0;
    cpl_tag_valid = 1'b1; cpl_tag = 10'h201;
    @(negedge clk);
    cmd_req_valid = 1'b0; cpl_tag = 10'h202;
    @(negedge clk);
    cpl_tag = 10'h203;
    @(negedge clk);
    cpl_tag_valid = 1'b0;
    total++; if (cmd_req_ready !== 1'b0 || free_en !== 1'b1) begin bad++; $display("FAIL mid_pre ready=%b free=%b exp 0/1", cmd_req_ready, free_en); end
    rst_n = 1'b0; hcmd_slot_rdy = 1'b1; hcmd_slot_tag = 10'h111;
    #1;
    total++; if ({cmd_req_ready, hcmd_slot_alloc_en, free_en} !== 3'b000 || cnt !== '0) begin bad++; $display("FAIL mid_in_reset r/a/f=%b cnt=%0d exp 000/0", {cmd_req_ready, hcmd_slot_alloc_en, free_en}, cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({cmd_req_ready, hcmd_slot_alloc_en, free_en, dbl_free_err} !== 4'b1000 || cnt !== '0) begin bad++; $display("FAIL mid_after%0d r/a/f/e=%b cnt=%0d exp 1000/0", i, {cmd_req_ready, hcmd_slot_alloc_en, free_en, dbl_free_err}, cnt); end
    end
    hcmd_slot_rdy = 1'b0;
  endtask

  initial begin
    test_reset;
    test_alloc;
    test_wait;
    @(negedge clk);
    test_burst;
    test_same_cycle;
    test_free_unalloc;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
